led_display_ctrl: RTL

- Avalon-MM slave that owns the 14-bit board LED bank and decides what drives it.
- Four sources, register-selected: CPU direct value, autonomous scrolling pattern, audio level meter with peak hold/decay, blank.
- Sits on the SoC's system bus alongside the other PIO-style peripherals. Takes the audio sample stream tap from the codec datapath.

---
 rtl/led_display_pkg.sv | 34 +++
 rtl/led_tick_gen.sv | 45 ++++
 rtl/led_display_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/led_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_display_pkg
// Purpose  : Shared definitions for the LED display controller: display mode
//            encodings, register word addresses, LED bank width, meter
//            ceiling and the saturating peak-decrement helper.
// Revision : 1.0 - initial release
// ============================================================================
package led_display_pkg;

  // Values of the mode field in the CTRL register.
  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_SCROLL = 2'd1,
    MODE_METER  = 2'd2,
    MODE_BLANK  = 2'd3
  } mode_t;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_DIRECT = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_SEED   = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  localparam int         LED_W     = 14;
  localparam logic [3:0] METER_MAX = 4'd14;

  // Peak decay step that stops at zero.
  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_tick_gen
// Purpose  : Step-period divider. Counts clk cycles while run is high and
//            emits a one-cycle tick every max(period,1) cycles.
// Ports    : clk, reset_n  - clock, asynchronous active-low reset
//            period        - cycles per tick (0 treated as 1)
//            run           - enable; counter held at 0 while low
//            clear         - synchronous counter restart
//            tick          - one-cycle step pulse
// Revision : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] period,
  input  logic             run,
  input  logic             clear,
  output logic             tick
);

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] w_last;

  // Terminal count; a zero period collapses to one cycle per tick.
  assign w_last = (period == '0) ? '0 : period - {{(DIV_W-1){1'b0}}, 1'b1};

  // Tick is decoded from the current count so a same-cycle clear still lets
  // this cycle's tick reach the rest of the design.
  assign tick = run & (r_count == w_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear || !run || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_display_ctrl
// Purpose  : Avalon-MM slave owning the board LED bank. Selects the LED drive
//            from a CPU direct value, a rotating scroll pattern, an audio
//            level meter with peak hold/decay, or blank.
// Ports    : clk, reset_n                 - clock, async active-low reset
//            address/chipselect/write_n/
//            writedata/readdata           - register bus, zero wait states
//            sample_valid, sample_data    - audio sample tap (signed)
//            led_out                      - registered LED drive
// Revision : 1.0 - initial release
// ============================================================================
module led_display_ctrl #(
  parameter int LED_W    = led_display_pkg::LED_W,
  parameter int DIV_W    = 24,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic [LED_W-1:0]    led_out
);

  import led_display_pkg::*;

  mode_t               r_mode;
  logic                r_run;
  logic [LED_W-1:0]    r_direct;
  logic [DIV_W-1:0]    r_period;
  logic [LED_W-1:0]    r_seed;
  logic [LED_W-1:0]    r_shift;
  logic [3:0]          r_peak;
  logic [LED_W-1:0]    r_led;

  logic                w_wr;
  logic                w_wr_ctrl;
  logic                w_wr_direct;
  logic                w_wr_period;
  logic                w_wr_seed;
  mode_t               w_wr_mode;
  logic                w_tick;
  logic [SAMPLE_W-1:0] w_abs;
  logic [3:0]          w_level_raw;
  logic [3:0]          w_level;
  logic [3:0]          w_peak_base;
  logic [LED_W-1:0]    w_therm;
  logic [LED_W-1:0]    w_led_next;
  logic                w_unused_bits;

  // --------------------------------------------------------------------------
  // Bus write decode
  // --------------------------------------------------------------------------
  assign w_wr        = chipselect & ~write_n;
  assign w_wr_ctrl   = w_wr & (address == ADDR_CTRL);
  assign w_wr_direct = w_wr & (address == ADDR_DIRECT);
  assign w_wr_period = w_wr & (address == ADDR_PERIOD);
  assign w_wr_seed   = w_wr & (address == ADDR_SEED);
  assign w_wr_mode   = mode_t'(writedata[1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode   <= MODE_DIRECT;
      r_run    <= 1'b0;
      r_direct <= '0;
      r_period <= '0;
      r_seed   <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_mode <= w_wr_mode;
        r_run  <= writedata[2];
      end
      if (w_wr_direct) r_direct <= writedata[LED_W-1:0];
      if (w_wr_period) r_period <= writedata[DIV_W-1:0];
      if (w_wr_seed)   r_seed   <= writedata[LED_W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Step tick; restarted whenever the period or control word is rewritten
  // --------------------------------------------------------------------------
  led_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (r_period),
    .run     (r_run),
    .clear   (w_wr_ctrl | w_wr_period),
    .tick    (w_tick)
  );

  // --------------------------------------------------------------------------
  // Scroll shift register. A SEED write outranks a coincident tick, and
  // entering scroll mode restarts the pattern from the stored seed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
    end else if (w_wr_seed) begin
      r_shift <= writedata[LED_W-1:0];
    end else if (w_wr_ctrl && (w_wr_mode == MODE_SCROLL) && (r_mode != MODE_SCROLL)) begin
      r_shift <= r_seed;
    end else if (w_tick && (r_mode == MODE_SCROLL)) begin
      r_shift <= {r_shift[LED_W-2:0], r_shift[LED_W-1]};
    end
  end

  // --------------------------------------------------------------------------
  // Level meter. The most negative sample saturates so its magnitude fits.
  // --------------------------------------------------------------------------
  always_comb begin
    w_abs = sample_data;
    if (sample_data == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
      w_abs = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (sample_data[SAMPLE_W-1]) begin
      w_abs = -sample_data;
    end
  end

  assign w_level_raw = w_abs[SAMPLE_W-2 -: 4];
  assign w_level     = (w_level_raw > METER_MAX) ? METER_MAX : w_level_raw;
  // A sample landing on a tick competes against the already-decayed peak.
  assign w_peak_base = w_tick ? sat_dec(r_peak) : r_peak;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_peak <= 4'd0;
    end else if (sample_valid) begin
      r_peak <= (w_level > w_peak_base) ? w_level : w_peak_base;
    end else if (w_tick) begin
      r_peak <= sat_dec(r_peak);
    end
  end

  for (genvar i = 0; i < LED_W; i++) begin : g_therm
    assign w_therm[i] = (32'(r_peak) > 32'(i));
  end

  // --------------------------------------------------------------------------
  // LED source select, registered
  // --------------------------------------------------------------------------
  always_comb begin
    w_led_next = '0;
    case (r_mode)
      MODE_DIRECT: w_led_next = r_direct;
      MODE_SCROLL: w_led_next = r_shift;
      MODE_METER:  w_led_next = w_therm;
      default:     w_led_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_next;
    end
  end

  assign led_out = r_led;

  // --------------------------------------------------------------------------
  // Read mux, combinational from address
  // --------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata[2:0]         = {r_run, r_mode};
      ADDR_DIRECT: readdata[LED_W-1:0]   = r_direct;
      ADDR_PERIOD: readdata[DIV_W-1:0]   = r_period;
      ADDR_SEED:   readdata[LED_W-1:0]   = r_seed;
      ADDR_STATUS: begin
        readdata[LED_W-1:0] = r_led;
        readdata[20:16]     = {1'b0, r_peak};
        readdata[24]        = r_run;
      end
      default:     readdata = '0;
    endcase
  end

  // Bits with no register home; gathered so they are visibly intentional.
  assign w_unused_bits = ^{writedata[31:DIV_W], w_abs[SAMPLE_W-1], w_abs[SAMPLE_W-6:0]};

endmodule
`default_nettype wire
